// File: rtl/div_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : div_sequencer
//  Purpose  : Front-end for the shared multi-cycle divider. Resolves the
//             RISC-V divide-by-zero and signed-overflow cases locally, reuses
//             the previous divider result via a one-entry operand cache, and
//             otherwise runs the divider under a watchdog. One response with
//             the destination tag is produced per accepted request.
//  Revision : 1.0  initial release
// ============================================================================
module div_sequencer #(
  parameter int XLEN    = 32,
  parameter int TAG_W   = 5,
  parameter int MAX_LAT = 64   // must be >= 2 and exceed divider latency
) (
  input  logic             clock,
  input  logic             reset,
  // request side
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [1:0]       req_op,
  input  logic [XLEN-1:0]  req_a,
  input  logic [XLEN-1:0]  req_b,
  input  logic [TAG_W-1:0] req_tag,
  input  logic             flush,
  // response side
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic [XLEN-1:0]  resp_data,
  output logic [TAG_W-1:0] resp_tag,
  output logic             resp_error,
  // divider side
  output logic [XLEN-1:0]  div_a,
  output logic [XLEN-1:0]  div_b,
  output logic             div_signed_a,
  output logic             div_signed_b,
  output logic             div_enable,
  input  logic [XLEN-1:0]  div_quotient,
  input  logic [XLEN-1:0]  div_remainder,
  input  logic             div_data_valid
);

  localparam int              CNT_W   = $clog2(MAX_LAT);
  localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t state, state_next;

  // request bookkeeping
  logic             sel_rem;
  logic [CNT_W-1:0] wd_cnt;

  // one-entry operand cache
  logic             cache_valid;
  logic [XLEN-1:0]  cache_a;
  logic [XLEN-1:0]  cache_b;
  logic             cache_signed;
  logic [XLEN-1:0]  cache_q;
  logic [XLEN-1:0]  cache_r;

  // request decode
  logic             accept;
  logic             req_signed;
  logic             is_div0;
  logic             is_ovf;
  logic             cache_hit;
  logic             fast_path;
  logic [XLEN-1:0]  fast_q;
  logic [XLEN-1:0]  fast_r;
  logic [XLEN-1:0]  fast_result;
  logic             wd_expired;

  assign req_ready   = (state == IDLE) && !flush && !reset;
  assign accept      = req_valid && req_ready;
  assign req_signed  = ~req_op[0];
  assign is_div0     = (req_b == '0);
  assign is_ovf      = req_signed && (req_a == INT_MIN) && (req_b == '1);
  assign cache_hit   = cache_valid && (cache_a == req_a) && (cache_b == req_b)
                       && (cache_signed == req_signed);
  assign fast_path   = is_div0 || is_ovf || cache_hit;
  // Priority: divide-by-zero, then overflow, then cached result.
  assign fast_q      = is_div0 ? '1 : (is_ovf ? INT_MIN : cache_q);
  assign fast_r      = is_div0 ? req_a : (is_ovf ? '0 : cache_r);
  assign fast_result = req_op[1] ? fast_r : fast_q;
  assign wd_expired  = (wd_cnt == CNT_W'(MAX_LAT - 1));

  // State register.
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic; flush always returns to IDLE and wins over completion.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (accept) begin
          state_next = fast_path ? RESP : BUSY;
        end
      end
      BUSY: begin
        if (flush) begin
          state_next = IDLE;
        end else if (div_data_valid || wd_expired) begin
          state_next = RESP;
        end
      end
      RESP: begin
        if (flush || resp_ready) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Datapath: divider drive, watchdog, cache and response registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      sel_rem      <= 1'b0;
      wd_cnt       <= '0;
      cache_valid  <= 1'b0;
      cache_a      <= '0;
      cache_b      <= '0;
      cache_signed <= 1'b0;
      cache_q      <= '0;
      cache_r      <= '0;
      resp_valid   <= 1'b0;
      resp_data    <= '0;
      resp_tag     <= '0;
      resp_error   <= 1'b0;
      div_enable   <= 1'b0;
      div_a        <= '0;
      div_b        <= '0;
      div_signed_a <= 1'b0;
      div_signed_b <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            resp_tag <= req_tag;
            sel_rem  <= req_op[1];
            if (fast_path) begin
              // Corner cases and hits never touch the divider or cache.
              resp_data  <= fast_result;
              resp_error <= 1'b0;
              resp_valid <= 1'b1;
            end else begin
              div_a        <= req_a;
              div_b        <= req_b;
              div_signed_a <= req_signed;
              div_signed_b <= req_signed;
              div_enable   <= 1'b1;
              wd_cnt       <= '0;
            end
          end
        end
        BUSY: begin
          if (flush) begin
            div_enable  <= 1'b0;
            cache_valid <= 1'b0;
          end else if (div_data_valid) begin
            cache_valid  <= 1'b1;
            cache_a      <= div_a;
            cache_b      <= div_b;
            cache_signed <= div_signed_a;
            cache_q      <= div_quotient;
            cache_r      <= div_remainder;
            resp_data    <= sel_rem ? div_remainder : div_quotient;
            resp_error   <= 1'b0;
            resp_valid   <= 1'b1;
            div_enable   <= 1'b0;
          end else if (wd_expired) begin
            // Divider hung: report an error and distrust the cache.
            cache_valid <= 1'b0;
            resp_data   <= '0;
            resp_error  <= 1'b1;
            resp_valid  <= 1'b1;
            div_enable  <= 1'b0;
          end else begin
            wd_cnt <= wd_cnt + 1'b1;
          end
        end
        RESP: begin
          if (flush || resp_ready) begin
            resp_valid <= 1'b0;
          end
        end
        default: begin
          resp_valid <= 1'b0;
          div_enable <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: doc/div_sequencer.md
# div_sequencer

Sequencer between the core's M-extension issue logic and the shared multi-cycle `divider`. Accepts DIV/DIVU/REM/REMU requests over a valid/ready handshake and resolves RISC-V corner cases (divide-by-zero, signed overflow) without using the divider. Reuses the last divider result through a one-entry operand cache, otherwise drives and monitors the divider with a watchdog. Returns one result per request with its destination tag.

## Interface
- `XLEN`, 32, operand/result width
- `TAG_W`, 5, request tag width (destination register index)
- `MAX_LAT`, 64, watchdog limit in BUSY cycles; must exceed the divider's worst-case latency
- `clock` in 1: sole clock, rising edge
- `reset` in 1: synchronous, active-high
- `req_valid` in 1: request present
- `req_ready` out 1: request accepted when `req_valid && req_ready` at a rising edge
- `req_op` in 2: 00 DIV, 01 DIVU, 10 REM, 11 REMU
- `req_a`, `req_b` in XLEN: dividend, divisor
- `req_tag` in TAG_W: returned unchanged with the result
- `flush` in 1: abort any in-flight request
- `resp_valid` out 1; `resp_ready` in 1: result handshake
- `resp_data` out XLEN: result
- `resp_tag` out TAG_W: tag of the result
- `resp_error` out 1: watchdog expired; `resp_data` is 0
- `div_a`, `div_b` out XLEN: divider operands
- `div_signed_a`, `div_signed_b` out 1: both equal `~op[0]`
- `div_enable` out 1: divider run
- `div_quotient`, `div_remainder` in XLEN: divider results
- `div_data_valid` in 1: divider results valid

## Operation
- Divider contract: operands are stable while `div_enable`=1. `div_data_valid` rises after the divider's latency. `div_enable`=0 for ≥1 cycle re-arms it. Signed results truncate toward zero.
- States are IDLE, BUSY and RESP.
- `req_ready` = (state==IDLE) && !flush && !reset.
- IDLE, on accept: latch op, a, b and tag. Signed = `~op[0]`. Select remainder = `op[1]`. Resolve in priority order:
  1. b==0: quotient = all ones, remainder = a; go to RESP.
  2. Signed && a==0x8000_0000 && b==all ones: quotient = 0x8000_0000, remainder = 0; go to RESP.
  3. Cache hit (cache valid, same a, b and signedness): take the cached quotient/remainder; go to RESP.
  4. Otherwise: clear the watchdog counter and go to BUSY.
- BUSY: `div_enable`=1 and `div_a/b/signed_*` come from latched registers. The counter increments each cycle.
  - On `div_data_valid`: write a, b, signedness, quotient and remainder into the cache and set it valid. Select the result and go to RESP.
  - If the counter reaches MAX_LAT−1 without valid: result 0, `resp_error`=1, cache invalidated, go to RESP.
- RESP: `resp_valid`=1. Data, tag and error are held stable until `resp_ready`, then go to IDLE. `div_enable`=0 in RESP, which guarantees the divider re-arm gap.
- Special cases never touch the divider or the cache.
- Flush in any state: next state IDLE, `resp_valid` and `div_enable` drop next cycle, no response is produced. Flush in BUSY also invalidates the cache. Flush with `req_valid` in the same cycle does not accept the request.
- Reset: state IDLE, cache invalid. `resp_valid`, `resp_data`, `resp_tag`, `resp_error`, `div_enable`, `div_a`, `div_b` and `div_signed_*` are all 0.

## Timing
- Special case or cache hit: accepted at edge N, `resp_valid`=1 in cycle N+1. Throughput is 1 result per 2 cycles with `resp_ready` tied high.
- Divider path: `div_enable`=1 from cycle N+1. If `div_data_valid` is sampled high at edge M, `resp_valid`=1 in cycle M+1 and `div_enable`=0 in the same cycle.
- Watchdog: `resp_valid` with `resp_error` appears MAX_LAT cycles after entering BUSY.
- All outputs are registered except `req_ready`.
- `div_data_valid` arriving after flush, or in IDLE/RESP, is ignored.
- Reset mid-BUSY: `div_enable` is 0 the next cycle.

## Test plan
- DIVU a=15634654, b=21354 with the behavioural divider: `div_enable` held high until valid, then resp_data=732 with the correct tag, `div_enable` low in the response cycle.
- REMU with the same operands immediately after: resp_data=3526 one cycle after accept, `div_enable` never rises (cache hit). REM with the same operands misses the cache (signedness differs) and uses the divider.
- DIV 5/0 → 0xFFFF_FFFF; REM 5/0 → 5; DIV 0x8000_0000/0xFFFF_FFFF → 0x8000_0000; REM of the same → 0. Each responds one cycle after accept with `div_enable` never high.
- DIV −7/2 → 0xFFFF_FFFD; REM −7/2 → 0xFFFF_FFFF. Hold `resp_ready`=0 for 5 cycles: data and tag stay stable, `req_ready`=0.
- Flush 3 cycles into BUSY: `div_enable` low next cycle, no response, a late `div_data_valid` is ignored, and reissuing the same operands misses the cache.
- Divider model that never asserts valid with MAX_LAT=64: response with `resp_error`=1 and data 0 exactly 64 cycles after entering BUSY. Reset asserted mid-BUSY returns all outputs to their reset values next cycle.
